multi_pulse_counter: RTL and testbench
======================================

# multi_pulse_counter

Parametrised multi-channel pulse/frequency counter. Each of `CH` asynchronous pulse inputs is synchronised and qualified as either an active-high level or a rising edge. Qualified events are accumulated over a common, programmable gate window. At the end of each window the block latches all channel counts simultaneously, flags saturation per channel and emits a one-cycle result strobe. It is the successor of the fixed 8-bit single-channel counter and feeds the segment-display and status-LED drivers.

## Interface
Parameters:
- `CH`, 4: number of independent pulse channels (≥1).
- `CNT_W`, 16: accumulator and result width per channel (2..32).
- `GATE_CYCLES`, 200_000_000: gate window length in enabled `clk_in` cycles (≥2).
- `EDGE_MODE`, 1: 1 counts rising edges; 0 counts cycles in which the input is high.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥1).

Ports:
- `clk_in`, in, 1: single clock for all logic.
- `rst_in`, in, 1: reset, synchronous and active-high.
- `enable_in`, in, 1: 1 means the gate timer and accumulators run; 0 freezes them.
- `clear_in`, in, 1: restarts the current window (timer and accumulators to 0); latched results are kept.
- `pulse_in`, in, CH: asynchronous pulse inputs; bit i is channel i.
- `count_out`, out, CH*CNT_W: latched counts; channel i occupies bits [i*CNT_W +: CNT_W].
- `ovf_out`, out, CH: per-channel saturation flag for the latched window.
- `valid_out`, out, 1: one-cycle strobe; `count_out` and `ovf_out` are updated in this same cycle.

## Operation
- **Synchroniser.** `s[i]` is `pulse_in[i]` after `SYNC_STAGES` flops. `s_d[i]` is `s[i]` delayed one cycle.
- **Event qualification.** With `EDGE_MODE`=1, `ev[i]` = `s[i] & ~s_d[i]`. With `EDGE_MODE`=0, `ev[i]` = `s[i]`.
- **Accumulators.**
  - Each cycle with `enable_in`=1, `acc[i]` increments by `ev[i]`.
  - `acc[i]` saturates at 2^CNT_W−1. An increment attempted at that value sets the window-sticky `sat[i]`; `acc[i]` never wraps.
- **Gate timer.**
  - `tim` counts 0..GATE_CYCLES−1 on enabled cycles.
  - The terminal cycle is `enable_in`=1 and `tim`==GATE_CYCLES−1.
  - A window therefore spans exactly GATE_CYCLES enabled cycles. Disabled cycles do not count.
- **Terminal cycle.** All of the following happen on the same edge:
  - `count_out[i]` ← saturating(`acc[i]` + `ev[i]`).
  - `ovf_out[i]` ← `sat[i]` OR (saturated `acc[i]` AND `ev[i]`).
  - `acc` ← 0, `sat` ← 0, `tim` ← 0.
  - `valid_out` ← 1.
- **All other cycles.**
  - `valid_out` ← 0.
  - `count_out` and `ovf_out` hold their values.
- **Priority.** `rst_in` > `clear_in` > terminal > normal accumulate.
  - `clear_in`=1 in a terminal cycle: clear wins. No latch happens and `valid_out` stays 0.
  - `clear_in` acts regardless of `enable_in`.
  - Events in a clear cycle are discarded.
- **enable_in=0.** `tim`, `acc` and `sat` hold. The synchroniser and `s_d` keep running, so an edge that occurs while disabled is lost, not deferred.
- **Channels are independent.** A saturation or event on channel i has no effect on channel j.

## Timing
- **Reset.** While `rst_in`=1 at a clock edge, all of the following go to 0: synchroniser flops, `s_d`, `acc`, `sat`, `tim`, `count_out`, `ovf_out`, `valid_out`. The first window starts on the first enabled cycle after reset deasserts. A reset mid-window discards the partial counts.
- **Pin to event.**
  - A `pulse_in` transition appears on `s` SYNC_STAGES edges later.
  - With `EDGE_MODE`=1, `ev` is combinational from `s` and `s_d`, so the event is counted in the cycle `s` rises.
- **Result latency.** The result is visible together with `valid_out`, on the edge that ends the terminal cycle.
- **Strobe spacing.** `valid_out` pulses are exactly GATE_CYCLES cycles apart when `enable_in` is held at 1 and `clear_in` at 0.
- **Pulse width.** With `EDGE_MODE`=1, pulses must be at least 1 cycle high and 1 cycle low after synchronisation to be counted distinctly. The maximum countable rate is f_clk/2.
- **Width rule.** Results are unsigned CNT_W bits. There is no internal wider adder visible at the outputs.

## Test plan
Benches use `CH`=4, `CNT_W`=4, `GATE_CYCLES`=10, `SYNC_STAGES`=2.

1. **Edge counting.** `EDGE_MODE`=1, `enable_in`=1. Drive channel 0 with 3 one-cycle pulses inside the first window -> `valid_out` high for 1 cycle exactly 10 cycles after the first enabled cycle; `count_out[3:0]`=3; other channels 0; `ovf_out`=0.
2. **Saturation.** `EDGE_MODE`=0, channel 1 held high for 20+ cycles -> window results `count_out[7:4]`=10 then 10; `ovf_out[1]`=0. Repeat with `GATE_CYCLES`=20 -> `count_out[7:4]`=15 and `ovf_out[1]`=1; the next window with channel 1 low gives 0 and `ovf_out[1]`=0.
3. **Enable freeze.** Deassert `enable_in` for 5 cycles mid-window while pulsing channel 2 -> pulses during the freeze are not counted; the `valid_out` strobe arrives 15 cycles after window start; the count includes only enabled-cycle edges.
4. **Clear against terminal.** Assert `clear_in` exactly in the terminal cycle -> no `valid_out`; `count_out` holds its previous values; the next strobe comes 10 enabled cycles later.
5. **Reset mid-window.** After 6 counted edges, assert `rst_in` for 1 cycle -> all outputs 0 on the next cycle; the following window reports only edges seen after reset.
6. **Terminal-cycle event.** Place an edge on channel 3 so that `ev[3]`=1 exactly in the terminal cycle -> it is included in that window's `count_out[15:12]` and not in the next window.

Source files
------------

// File: rtl/multi_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_pulse_counter
// Description : Multi-channel pulse/frequency counter. Each asynchronous
//               pulse input is synchronised, qualified as a rising edge or
//               a high level, and accumulated over a shared gate window.
//               At the end of every window all channel counts and their
//               saturation flags are latched together with a 1-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pulse_counter #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 200_000_000,
  parameter int EDGE_MODE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic                  clear_in,
  input  logic [CH-1:0]         pulse_in,
  output logic [CH*CNT_W-1:0]   count_out,
  output logic [CH-1:0]         ovf_out,
  output logic                  valid_out
);

  localparam int               c_TIM_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_TIM_W-1:0] c_TIM_LAST = c_TIM_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  logic [CH-1:0]        r_sync [SYNC_STAGES];
  logic [CH-1:0]        r_sd;
  logic [CH-1:0]        w_s;
  logic [CH-1:0]        w_ev;
  logic [CH*CNT_W-1:0]  r_acc;
  logic [CH-1:0]        r_sat;
  logic [c_TIM_W-1:0]   r_tim;
  logic [CH*CNT_W-1:0]  w_acc_next;
  logic [CH-1:0]        w_sat_next;
  logic                 w_term;

  // Synchroniser chain plus one-cycle delayed copy used for edge detection;
  // keeps running while disabled so edges during a freeze are lost.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_sd <= '0;
    end else begin
      r_sync[0] <= pulse_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_sd <= w_s;
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign w_ev = w_s & ~r_sd;
    end else begin : g_level
      assign w_ev = w_s;
    end
  endgenerate

  // Per-channel saturating increment; an event arriving at full scale is
  // dropped from the count but recorded in the sticky saturation flag.
  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      logic w_at_max;
      logic w_inc;
      assign w_at_max = (r_acc[i*CNT_W +: CNT_W] == c_CNT_MAX);
      assign w_inc    = w_ev[i] & ~w_at_max;
      assign w_acc_next[i*CNT_W +: CNT_W] =
        r_acc[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, w_inc};
      assign w_sat_next[i] = r_sat[i] | (w_at_max & w_ev[i]);
    end
  endgenerate

  assign w_term = enable_in & (r_tim == c_TIM_LAST);

  // Gate timer, accumulators and result latch. Clear beats the terminal
  // cycle, so a clear in that cycle suppresses both the latch and strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_acc     <= '0;
      r_sat     <= '0;
      r_tim     <= '0;
      count_out <= '0;
      ovf_out   <= '0;
      valid_out <= 1'b0;
    end else if (clear_in) begin
      r_acc     <= '0;
      r_sat     <= '0;
      r_tim     <= '0;
      valid_out <= 1'b0;
    end else if (w_term) begin
      count_out <= w_acc_next;
      ovf_out   <= w_sat_next;
      r_acc     <= '0;
      r_sat     <= '0;
      r_tim     <= '0;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
      if (enable_in) begin
        r_acc <= w_acc_next;
        r_sat <= w_sat_next;
        r_tim <= r_tim + c_TIM_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_pulse_counter
// Description : Bench for multi_pulse_counter. Three instances (edge/10,
//               level/10, level/20) share the stimulus and are compared each
//               cycle with an unbounded-count reference model; directed
//               scenarios add fixed expected values on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pulse_counter;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int NCFG = 3;
  localparam int E_CFG [NCFG] = '{1, 0, 0};
  localparam int G_CFG [NCFG] = '{10, 10, 20};

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [CH-1:0] pulse;
  logic [15:0]   d_cnt [NCFG];
  logic [3:0]    d_ovf [NCFG];
  logic          d_val [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_pulse_counter #(.CH(CH), .CNT_W(W), .GATE_CYCLES(10), .EDGE_MODE(1), .SYNC_STAGES(SYNC)) u_e10 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .clear_in(clr), .pulse_in(pulse),
    .count_out(d_cnt[0]), .ovf_out(d_ovf[0]), .valid_out(d_val[0]));
  multi_pulse_counter #(.CH(CH), .CNT_W(W), .GATE_CYCLES(10), .EDGE_MODE(0), .SYNC_STAGES(SYNC)) u_l10 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .clear_in(clr), .pulse_in(pulse),
    .count_out(d_cnt[1]), .ovf_out(d_ovf[1]), .valid_out(d_val[1]));
  multi_pulse_counter #(.CH(CH), .CNT_W(W), .GATE_CYCLES(20), .EDGE_MODE(0), .SYNC_STAGES(SYNC)) u_l20 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .clear_in(clr), .pulse_in(pulse),
    .count_out(d_cnt[2]), .ovf_out(d_ovf[2]), .valid_out(d_val[2]));

  // Reference model: true (unbounded) event totals per window; saturation
  // is only applied when the window result is published.
  logic [CH-1:0] ph [0:SYNC];
  int            m_acc [NCFG][CH];
  int            m_tim [NCFG];
  logic [15:0]   m_cnt [NCFG];
  logic [3:0]    m_ovf [NCFG];
  logic          m_val [NCFG];

  always @(posedge clk) begin
    logic [CH-1:0] s, sd, ev;
    int tot;
    if (rst) begin
      for (int j = 0; j <= SYNC; j++) ph[j] = '0;
      for (int c = 0; c < NCFG; c++) begin
        for (int ch = 0; ch < CH; ch++) m_acc[c][ch] = 0;
        m_tim[c] = 0; m_cnt[c] = '0; m_ovf[c] = '0; m_val[c] = 1'b0;
      end
    end else begin
      s  = ph[SYNC-1];
      sd = ph[SYNC];
      for (int c = 0; c < NCFG; c++) begin
        ev = (E_CFG[c] != 0) ? (s & ~sd) : s;
        if (clr) begin
          for (int ch = 0; ch < CH; ch++) m_acc[c][ch] = 0;
          m_tim[c] = 0; m_val[c] = 1'b0;
        end else if (en && m_tim[c] == G_CFG[c] - 1) begin
          for (int ch = 0; ch < CH; ch++) begin
            tot = m_acc[c][ch] + int'(ev[ch]);
            m_cnt[c][ch*W +: W] = (tot > 15) ? 4'd15 : 4'(tot);
            m_ovf[c][ch] = (tot > 15);
            m_acc[c][ch] = 0;
          end
          m_tim[c] = 0; m_val[c] = 1'b1;
        end else begin
          m_val[c] = 1'b0;
          if (en) begin
            for (int ch = 0; ch < CH; ch++) m_acc[c][ch] += int'(ev[ch]);
            m_tim[c]++;
          end
        end
      end
      for (int j = SYNC; j >= 1; j--) ph[j] = ph[j-1];
      ph[0] = pulse;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("model_cnt%0d", c), 32'(d_cnt[c]), 32'(m_cnt[c]));
      chk($sformatf("model_ovf%0d", c), 32'(d_ovf[c]), 32'(m_ovf[c]));
      chk($sformatf("model_val%0d", c), 32'(d_val[c]), 32'(m_val[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; en = 1'b0; clr = 1'b0; pulse = '0;
    tick(); tick();
    for (int c = 0; c < NCFG; c++) begin
      chk("reset_cnt", 32'(d_cnt[c]), 32'h0);
      chk("reset_ovf", 32'(d_ovf[c]), 32'h0);
      chk("reset_val", 32'(d_val[c]), 32'h0);
    end
    rst = 1'b0;
    tick();

    // Edge counting: three pulses on channel 0 in the first window
    en = 1'b1; lat = 0;
    for (int k = 0; k < 30; k++) begin
      pulse[0] = (k == 0 || k == 2 || k == 4);
      tick();
      if (d_val[0]) begin lat = k + 1; break; end
    end
    chk("t1_latency", 32'(lat), 32'd10);
    chk("t1_count", 32'(d_cnt[0]), 32'h0003);
    chk("t1_ovf", 32'(d_ovf[0]), 32'h0);

    // Saturation in level mode
    pulse = 4'b0010;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) tick();
    chk("t2_l10_val", 32'(d_val[1]), 32'd1);
    chk("t2_l10_cnt", 32'(d_cnt[1][7:4]), 32'd10);
    chk("t2_l10_ovf", 32'(d_ovf[1][1]), 32'd0);
    repeat (10) tick();
    chk("t2_l10_cnt2", 32'(d_cnt[1][7:4]), 32'd10);
    chk("t2_l20_val", 32'(d_val[2]), 32'd1);
    chk("t2_l20_cnt", 32'(d_cnt[2][7:4]), 32'd15);
    chk("t2_l20_ovf", 32'(d_ovf[2][1]), 32'd1);
    pulse = '0;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (20) tick();
    chk("t2_l20_val2", 32'(d_val[2]), 32'd1);
    chk("t2_l20_cnt2", 32'(d_cnt[2][7:4]), 32'd0);
    chk("t2_l20_ovf2", 32'(d_ovf[2][1]), 32'd0);

    // Enable freeze for 5 cycles while channel 2 keeps pulsing
    clr = 1'b1; tick(); clr = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      en = !(k >= 4 && k < 9);
      pulse[2] = (k % 2 == 0);
      tick();
      if (d_val[0]) begin lat = k + 1; break; end
    end
    en = 1'b1; pulse = '0;
    chk("t3_latency", 32'(lat), 32'd15);
    chk("t3_count", 32'(d_cnt[0]), 32'h0400);

    // Clear asserted exactly in the terminal cycle
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (9) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_noval", 32'(d_val[0]), 32'd0);
    chk("t4_hold", 32'(d_cnt[0]), 32'h0400);
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (d_val[0]) begin lat = k + 1; break; end
    end
    chk("t4_latency", 32'(lat), 32'd10);

    // Reset mid-window after six edges
    for (int k = 0; k < 12; k++) begin
      pulse[0] = (k % 2 == 0);
      tick();
    end
    pulse = '0; rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      chk("t5_rst_cnt", 32'(d_cnt[c]), 32'h0);
      chk("t5_rst_ovf", 32'(d_ovf[c]), 32'h0);
      chk("t5_rst_val", 32'(d_val[c]), 32'h0);
    end
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      pulse[0] = (k == 0 || k == 2);
      tick();
      if (d_val[0]) begin lat = k + 1; break; end
    end
    chk("t5_latency", 32'(lat), 32'd10);
    chk("t5_count", 32'(d_cnt[0]), 32'h0002);

    // Event on channel 3 exactly in the terminal cycle
    pulse = '0;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      pulse[3] = (t == 8);
      tick();
    end
    chk("t6_val", 32'(d_val[0]), 32'd1);
    chk("t6_cnt", 32'(d_cnt[0][15:12]), 32'd1);
    pulse = '0;
    repeat (10) tick();
    chk("t6_val2", 32'(d_val[0]), 32'd1);
    chk("t6_cnt2", 32'(d_cnt[0][15:12]), 32'd0);

    // Randomised traffic with occasional freezes and clears
    for (int k = 0; k < 400; k++) begin
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      pulse = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
